// File: rtl/uart_mem_loader_if.sv
// uart_mem_loader_if
// Write-only memory bus driven by the UART boot loader.
//   mem_req   : write request, held until granted
//   mem_gnt   : grant, the write completes on mem_req && mem_gnt
//   mem_addr  : word-aligned byte address
//   mem_wdata : write data
//   mem_be    : byte enables, 4'hF while mem_req is high
interface uart_mem_loader_if;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;

    modport master (output mem_req, mem_addr, mem_wdata, mem_be, input mem_gnt);
    modport slave  (input mem_req, mem_addr, mem_wdata, mem_be, output mem_gnt);
endinterface

// File: rtl/uart_mem_loader.sv
// uart_mem_loader
// Receives 8N1 bytes on uart_rx and parses host boot-load frames:
//   0x02 + 4-byte BE address + BURST_WORDS BE 32-bit words -> one bus write per word
//   0x03                                                    -> sets fetch_en
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   uart_rx       : serial input, idle high, asynchronous to clk
//   mem           : write bus (master side)
//   fetch_en      : sticky core fetch enable
//   busy          : parser not idle or write pending
//   frame_err     : sticky, stop bit sampled low
//   cmd_err       : sticky, unknown command byte
//   overrun_err   : sticky, word completed while previous write still ungranted
module uart_mem_loader #(
    parameter int CLKS_PER_BIT   = 64,
    parameter int BURST_WORDS    = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               uart_rx,
    uart_mem_loader_if.master  mem,
    output logic               fetch_en,
    output logic               busy,
    output logic               frame_err,
    output logic               cmd_err,
    output logic               overrun_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int WC_W  = $clog2(BURST_WORDS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {P_IDLE, P_ADDR, P_DATA} p_state_t;

    // ---------------- RX input synchroniser ----------------
    logic r_sync1, r_sync2, r_rx_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= uart_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t        r_rx_state, w_rx_next;
    logic [CNT_W-1:0] r_clk_cnt, w_cnt_tgt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_stop_wait;   // bad stop bit seen, waiting for line to return high
    logic             w_tick, w_byte_valid, w_frame_set;

    // Start bit is checked at mid-bit, every later sample is one full bit on.
    always_comb begin
        w_cnt_tgt = (r_rx_state == RX_START) ? CNT_W'(CLKS_PER_BIT / 2 - 1)
                                             : CNT_W'(CLKS_PER_BIT - 1);
    end
    assign w_tick = (r_clk_cnt == w_cnt_tgt);

    always_ff @(posedge clk) begin
        if (reset) r_rx_state <= RX_IDLE;
        else       r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (r_rx_prev && !r_sync2) w_rx_next = RX_START;
            RX_START: if (w_tick) w_rx_next = r_sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_tick && r_bit_cnt == 3'd7) w_rx_next = RX_STOP;
            RX_STOP: begin
                if (r_stop_wait) begin
                    if (r_sync2) w_rx_next = RX_IDLE;
                end else if (w_tick && r_sync2) begin
                    w_rx_next = RX_IDLE;
                end
            end
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        w_byte_valid = (r_rx_state == RX_STOP) && !r_stop_wait && w_tick &&  r_sync2;
        w_frame_set  = (r_rx_state == RX_STOP) && !r_stop_wait && w_tick && !r_sync2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_stop_wait <= 1'b0;
        end else begin
            if (r_rx_state == RX_IDLE || w_rx_next != r_rx_state || w_tick)
                r_clk_cnt <= '0;
            else
                r_clk_cnt <= r_clk_cnt + 1'b1;

            if (r_rx_state == RX_IDLE) begin
                r_bit_cnt <= '0;
            end else if (r_rx_state == RX_DATA && w_tick) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_shift   <= {r_sync2, r_shift[7:1]};   // LSB first
            end

            if (w_frame_set)               r_stop_wait <= 1'b1;
            else if (w_rx_next == RX_IDLE) r_stop_wait <= 1'b0;
        end
    end

    // ---------------- Frame parser ----------------
    p_state_t        r_p_state, w_p_next;
    logic [1:0]      r_byte_cnt;
    logic [WC_W-1:0] r_word_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic [31:0]     r_addr, r_word;
    logic            r_mem_req, r_fetch_en, r_frame_err, r_cmd_err, r_overrun_err;
    logic [31:0]     r_mem_addr, r_mem_wdata;
    logic            w_timeout, w_word_done, w_load, w_overrun, w_gnt_now;

    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) r_p_state <= P_IDLE;
        else       r_p_state <= w_p_next;
    end

    always_comb begin
        w_p_next = r_p_state;
        case (r_p_state)
            P_IDLE: if (w_byte_valid && r_shift == 8'h02) w_p_next = P_ADDR;
            P_ADDR: begin
                if (w_byte_valid) begin
                    if (r_byte_cnt == 2'd3) w_p_next = P_DATA;
                end else if (w_timeout) begin
                    w_p_next = P_IDLE;
                end
            end
            P_DATA: begin
                if (w_byte_valid) begin
                    if (r_byte_cnt == 2'd3 && r_word_cnt == WC_W'(BURST_WORDS - 1))
                        w_p_next = P_IDLE;
                end else if (w_timeout) begin
                    w_p_next = P_IDLE;
                end
            end
            default: w_p_next = P_IDLE;
        endcase
    end

    // A grant in the same cycle as a word completion frees the slot, so the
    // new word loads instead of counting as an overrun.
    always_comb begin
        w_gnt_now   = r_mem_req && mem.mem_gnt;
        w_word_done = (r_p_state == P_DATA) && w_byte_valid && (r_byte_cnt == 2'd3);
        w_load      = w_word_done && (!r_mem_req || w_gnt_now);
        w_overrun   = w_word_done && r_mem_req && !w_gnt_now;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_cnt    <= '0;
            r_word_cnt    <= '0;
            r_to_cnt      <= '0;
            r_addr        <= '0;
            r_word        <= '0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_fetch_en    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_cmd_err     <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            if (w_byte_valid || r_p_state == P_IDLE) r_to_cnt <= '0;
            else                                     r_to_cnt <= r_to_cnt + 1'b1;

            if (r_p_state == P_IDLE)  r_byte_cnt <= '0;
            else if (w_byte_valid)    r_byte_cnt <= r_byte_cnt + 1'b1;

            if (r_p_state == P_ADDR)  r_word_cnt <= '0;
            else if (w_word_done)     r_word_cnt <= r_word_cnt + 1'b1;

            if (r_p_state == P_ADDR && w_byte_valid) begin
                if (r_byte_cnt == 2'd3) r_addr <= {r_addr[23:0], r_shift[7:2], 2'b00};
                else                    r_addr <= {r_addr[23:0], r_shift};
            end else if (w_word_done) begin
                r_addr <= r_addr + 32'd4;
            end

            if (r_p_state == P_DATA && w_byte_valid) r_word <= {r_word[23:0], r_shift};

            if (w_load) begin
                r_mem_req   <= 1'b1;
                r_mem_addr  <= r_addr;
                r_mem_wdata <= {r_word[23:0], r_shift};
            end else if (w_gnt_now) begin
                r_mem_req   <= 1'b0;
            end

            if (r_p_state == P_IDLE && w_byte_valid) begin
                if (r_shift == 8'h03)      r_fetch_en <= 1'b1;
                else if (r_shift != 8'h02) r_cmd_err  <= 1'b1;
            end
            if (w_frame_set) r_frame_err   <= 1'b1;
            if (w_overrun)   r_overrun_err <= 1'b1;
        end
    end

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign mem.mem_be    = r_mem_req ? 4'hF : 4'h0;
    assign fetch_en      = r_fetch_en;
    assign busy          = (r_p_state != P_IDLE) || r_mem_req;
    assign frame_err     = r_frame_err;
    assign cmd_err       = r_cmd_err;
    assign overrun_err   = r_overrun_err;
endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader
// Serial stimulus into uart_mem_loader; expected writes are queued when a
// frame is sent and compared by a bus monitor as grants complete.
module tb_uart_mem_loader;
    localparam int CPB = 16;
    localparam int BW  = 4;
    localparam int TO  = 2000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_rx = 1'b1;
    logic fetch_en, busy, frame_err, cmd_err, overrun_err;

    uart_mem_loader_if bus();

    uart_mem_loader #(.CLKS_PER_BIT(CPB), .BURST_WORDS(BW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .mem(bus),
        .fetch_en(fetch_en), .busy(busy), .frame_err(frame_err),
        .cmd_err(cmd_err), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb_q[$];
    logic        stab_arm = 1'b0;
    logic [63:0] stab_val;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus monitor: compare granted writes to the scoreboard, and make sure a
    // waiting request holds its address and data.
    always @(negedge clk) begin
        if (reset) begin
            stab_arm = 1'b0;
        end else if (bus.mem_req) begin
            if (stab_arm) check("hold_stable", {bus.mem_addr, bus.mem_wdata}, stab_val);
            if (bus.mem_gnt) begin
                check("mem_be", 64'(bus.mem_be), 64'h0F);
                if (sb_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_write: got %h expected none",
                             {bus.mem_addr, bus.mem_wdata});
                end else begin
                    check("write", {bus.mem_addr, bus.mem_wdata}, sb_q.pop_front());
                end
                stab_arm = 1'b0;
            end else begin
                stab_arm = 1'b1;
                stab_val = {bus.mem_addr, bus.mem_wdata};
            end
        end else begin
            stab_arm = 1'b0;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        uart_rx = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin uart_rx = b[i]; tick(CPB); end
        uart_rx = stop_bit; tick(CPB);
        uart_rx = 1'b1; tick(2);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic send_hdr(input logic [31:0] a);
        send_byte(8'h02);
        send_word(a);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || sb_q.size() != 0) && n < 5000) begin tick(1); n++; end
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_pending"}, 64'(sb_q.size()), 64'd0);
    endtask

    typedef struct {
        logic [31:0]       addr_in;
        logic [31:0]       addr_exp;
        logic [3:0][31:0]  w;       // w[0] sent first
    } burst_t;

    burst_t tbl[3];

    initial begin
        logic [31:0] a;
        tbl[0] = '{32'h00008000, 32'h00008000,
                   {32'hDDEEFF00, 32'h99AABBCC, 32'h55667788, 32'h11223344}};
        tbl[1] = '{32'h00001003, 32'h00001000,
                   {32'h0000_0004, 32'hFFFF_FFFF, 32'h8000_0001, 32'hCAFE_F00D}};
        tbl[2] = '{32'hFFFFFFF9, 32'hFFFFFFF8,
                   {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}};

        bus.mem_gnt = 1'b1;
        reset = 1'b1;
        tick(3);
        check("reset_outputs",
              {bus.mem_req, bus.mem_addr, bus.mem_wdata[15:0], bus.mem_be,
               fetch_en, busy, frame_err, cmd_err, overrun_err},
              64'd0);
        reset = 1'b0;
        tick(5);

        // Write bursts with grant tied high, including unaligned and wrapping addresses
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < BW; j++) begin
                a = tbl[i].addr_exp + 32'(4 * j);
                sb_q.push_back({a, tbl[i].w[j]});
            end
            send_hdr(tbl[i].addr_in);
            for (int j = 0; j < BW; j++) send_word(tbl[i].w[j]);
            wait_idle($sformatf("burst%0d", i));
        end

        // Short low pulse must not produce a byte
        uart_rx = 1'b0; tick(CPB / 4); uart_rx = 1'b1;
        tick(3 * CPB);
        check("glitch_busy", 64'(busy), 64'd0);
        check("glitch_cmd_err", 64'(cmd_err), 64'd0);

        // Timeout mid-address, then a fresh frame must parse cleanly
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        tick(TO / 2);
        check("timeout_still_busy", 64'(busy), 64'd1);
        tick(TO);
        check("timeout_idle", 64'(busy), 64'd0);
        for (int j = 0; j < BW; j++) sb_q.push_back({32'h00100000 + 32'(4 * j), 32'hA5A50000 + 32'(j)});
        send_hdr(32'h00100000);
        for (int j = 0; j < BW; j++) send_word(32'hA5A50000 + 32'(j));
        wait_idle("timeout_frame");

        // Unknown command
        check("cmd_err_before", 64'(cmd_err), 64'd0);
        send_byte(8'h55);
        tick(5);
        check("cmd_err_after", 64'(cmd_err), 64'd1);
        check("cmd_err_busy", 64'(busy), 64'd0);

        // Bad stop bit, then run command still accepted
        check("frame_err_before", {62'd0, frame_err, fetch_en}, 64'd0);
        send_byte(8'h00, 1'b0);
        tick(CPB);
        check("frame_err_after", {62'd0, frame_err, fetch_en}, 64'd2);
        send_byte(8'h03);
        tick(5);
        check("fetch_en", 64'(fetch_en), 64'd1);

        // Backpressure: word 1 held, word 2 dropped, words 3/4 written
        check("overrun_before", 64'(overrun_err), 64'd0);
        bus.mem_gnt = 1'b0;
        sb_q.push_back({32'h00008000, 32'h11223344});
        sb_q.push_back({32'h00008008, 32'h99AABBCC});
        sb_q.push_back({32'h0000800C, 32'hDDEEFF00});
        send_hdr(32'h00008000);
        send_word(32'h11223344);
        tick(10 * CPB);
        check("bp_held", {31'd0, bus.mem_req, bus.mem_addr}, {31'd0, 1'b1, 32'h00008000});
        check("bp_held_data", 64'(bus.mem_wdata), 64'h11223344);
        send_word(32'h55667788);
        check("overrun_after", 64'(overrun_err), 64'd1);
        bus.mem_gnt = 1'b1;
        send_word(32'h99AABBCC);
        send_word(32'hDDEEFF00);
        wait_idle("backpressure");

        // Reset in the middle of a data phase with a request pending
        bus.mem_gnt = 1'b0;
        send_hdr(32'h00009000);
        send_word(32'h01020304);
        check("rst_req_pending", 64'(bus.mem_req), 64'd1);
        send_byte(8'h05); send_byte(8'h06);
        reset = 1'b1;
        tick(1);
        check("rst_mid_data",
              {bus.mem_req, busy, fetch_en, frame_err, cmd_err, overrun_err, 26'd0, bus.mem_addr},
              64'd0);
        sb_q.delete();
        reset = 1'b0;
        bus.mem_gnt = 1'b1;
        tick(5);
        for (int j = 0; j < BW; j++) sb_q.push_back({32'h00000200 + 32'(4 * j), 32'h5A000000 + 32'(j)});
        send_hdr(32'h00000200);
        for (int j = 0; j < BW; j++) send_word(32'h5A000000 + 32'(j));
        wait_idle("after_reset");
        check("flags_after_reset", {61'd0, frame_err, cmd_err, overrun_err}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- FPGA-side responder for the host UART boot-load protocol: 8N1 bytes arrive on `uart_rx`; a write command is `0x02`, a 4-byte big-endian address, then BURST_WORDS big-endian 32-bit data words.
- Deserialises bytes, parses frames and issues one 32-bit memory write per data word on a req/gnt bus into instruction/data RAM.
- Command `0x03` raises `fetch_en` to release the core after loading.
- Sits in the FPGA top level between the UART pin and the memory interconnect.

Parameters:
- CLKS_PER_BIT, 64, clk cycles per UART bit (100 MHz / 1 562 500 baud); minimum 4.
- BURST_WORDS, 4, data words following each `0x02` command+address.
- TIMEOUT_CYCLES, 65536, idle clk cycles mid-frame before the parser aborts to IDLE.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous active-high reset.
- `uart_rx` in 1: serial input, idle high, asynchronous to clk.
- `mem_req` out 1: write request, held until granted.
- `mem_gnt` in 1: grant; the write completes on the cycle `mem_req && mem_gnt`.
- `mem_addr` out 32: byte address, word aligned.
- `mem_wdata` out 32: write data.
- `mem_be` out 4: byte enables, constant `4'hF` while `mem_req`, else 0.
- `fetch_en` out 1: core fetch enable, sticky once set.
- `busy` out 1: parser not in IDLE, or `mem_req` pending.
- `frame_err` out 1: sticky, stop bit sampled low.
- `cmd_err` out 1: sticky, unknown command byte received.
- `overrun_err` out 1: sticky, word completed while the previous write was still ungranted.

Behaviour:
- Reset (synchronous, `reset` high at a posedge):
  - all outputs 0, `mem_addr`/`mem_wdata` 0;
  - RX FSM to RX_IDLE, parser to IDLE;
  - reset mid-byte or mid-frame discards all partial state, and a pending `mem_req` is dropped.
- RX input sync: `uart_rx` passes through a 2-flop synchroniser; the synchroniser flops reset to 1.
- RX FSM states RX_IDLE, RX_START, RX_DATA, RX_STOP:
  - RX_IDLE: a falling edge on the synced input enters RX_START and clears the bit counter.
  - RX_START: resample at CLKS_PER_BIT/2. If high (glitch), return to RX_IDLE with no byte; otherwise go to RX_DATA.
  - RX_DATA: sample every CLKS_PER_BIT, LSB first, for 8 bits.
  - RX_STOP: sample one CLKS_PER_BIT later.
    - High: assert an internal `byte_valid` for exactly 1 cycle.
    - Low: set `frame_err`, no `byte_valid`, and wait for the line to go high before RX_IDLE.
- Parser states IDLE, ADDR, DATA:
  - IDLE, byte `0x02`: go to ADDR; byte counter = 0.
  - IDLE, byte `0x03`: set `fetch_en`; stay IDLE.
  - IDLE, any other byte: set `cmd_err`; stay IDLE.
  - ADDR: shift bytes MSB first into the address register. After the 4th byte, force `addr[1:0]=0`, set word count = 0, go to DATA.
  - DATA: shift bytes MSB first into the word register. On the 4th byte the word completes:
    - if `mem_req` is low: load `mem_addr` = current address and `mem_wdata` = word, raise `mem_req` the next cycle, and add 4 to the current address (32-bit wrap at `0xFFFFFFFC` to 0);
    - if `mem_req` is still high: set `overrun_err`, drop the word, and still advance address and count.
  - After BURST_WORDS words, return to IDLE.
- Timeout: in ADDR or DATA, if no `byte_valid` arrives for TIMEOUT_CYCLES cycles, return to IDLE and discard the partial frame. No error flag is raised.
- Write bus: `mem_req` stays high with stable `addr`/`wdata`/`be` until the `mem_gnt` cycle, and drops the cycle after. A gnt in the same cycle as req rise is legal, giving a 1-cycle request. `mem_gnt` while `mem_req` is low is ignored.
- Latency: `mem_req` rises 1 clk after the stop-bit sample of the 4th data byte.
- Same-cycle events: grant and a new word completion in the same cycle is not an overrun. The new word loads and `mem_req` stays high for it.
- Error flags and `fetch_en` clear only on reset.

Test Plan:
- Write burst: send `02 00 00 80 00` then `11 22 33 44`, `55 66 77 88`, `99 AA BB CC`, `DD EE FF 00` with `mem_gnt` tied high. Expect 4 writes: `0x00008000`=`0x11223344`, `0x8004`=`0x55667788`, `0x8008`=`0x99AABBCC`, `0x800C`=`0xDDEEFF00`, `mem_be`=`F`, then `busy`=0.
- Backpressure: same frame with `mem_gnt` held low for 10 bit-times after the first req. Expect word 1 held stable, then word 2 lost, `overrun_err`=1, and word 3 written at `0x8008`.
- Command/framing errors:
  - byte `0x55` in IDLE gives `cmd_err`=1 with no write;
  - a byte with the stop bit forced low gives `frame_err`=1, after which a valid `0x03` still sets `fetch_en`=1.
- Timeout: send `02 00 00` then idle for more than TIMEOUT_CYCLES. The parser returns to IDLE, and a fresh full frame to `0x00100000` writes correctly.
- Glitch and reset:
  - a low pulse of CLKS_PER_BIT/4 on `uart_rx` yields no byte;
  - asserting `reset` mid-DATA clears `mem_req`, `busy` and all flags within 1 cycle.
